mem_stage_hs: RTL and testbench

Parametrised, handshaked successor of the pipeline memory stage for the RISC-V core. It sits between execution and writeback and does the following:
- resolves branches;
- formats stores (byte enables, lane shift);
- issues requests to a variable-latency data memory over a valid/ready bus;
- aligns and extends load data.

It stalls execution while a memory access is outstanding and holds its writeback output until writeback accepts it.

---
 rtl/mem_stage_hs_pkg.sv | 28 ++
 rtl/mem_stage_hs_if.sv | 23 ++
 rtl/mem_stage_hs_load_align.sv | 28 ++
 rtl/mem_stage_hs.sv | 217 +++++++++++++++++++++
 tb/tb_mem_stage_hs.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_hs_pkg.sv
// Shared funct3 encodings, memory FSM states and alignment helper for the memory stage.
package riscv_mem_pkg;
    localparam logic [2:0] F3_LB   = 3'b000;
    localparam logic [2:0] F3_LH   = 3'b001;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_LBU  = 3'b100;
    localparam logic [2:0] F3_LHU  = 3'b101;
    localparam logic [2:0] F3_SB   = 3'b000;
    localparam logic [2:0] F3_SH   = 3'b001;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} mem_state_t;

    // funct3[1:0]: 00 byte, 01 half, anything else is a word access
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = off[0];
            default: misaligned = (off != 2'b00);
        endcase
    endfunction
endpackage

// File: rtl/mem_stage_hs_if.sv
// Valid/ready data-memory bus between the memory stage (master) and data memory (slave).
interface mem_stage_hs_if #(
    parameter int XLEN    = 32,
    parameter int DADDR_W = 30
);
    logic               dmem_req_valid;
    logic               dmem_req_ready;
    logic               dmem_we;
    logic [DADDR_W-1:0] dmem_addr;
    logic [3:0]         dmem_be;
    logic [XLEN-1:0]    dmem_wdata;
    logic               dmem_rsp_valid;
    logic [XLEN-1:0]    dmem_rdata;

    modport master (
        output dmem_req_valid, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_req_ready, dmem_rsp_valid, dmem_rdata
    );
    modport slave (
        input  dmem_req_valid, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_req_ready, dmem_rsp_valid, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_hs_load_align.sv
// Load alignment: picks the byte/half lane from the raw word and sign/zero extends it.
// Latency: combinational.
// Backpressure: none.
module load_align_unit
    import riscv_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{off, 3'b000} +: 8];
        half_sel = rdata[{off[1], 4'b0000} +: 16];
        case (funct3)
            F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
            default: result = rdata;
        endcase
    end
endmodule

// File: rtl/mem_stage_hs.sv
// Memory stage: resolves branches, formats stores, issues dmem requests, aligns load data.
// Latency: 1 cycle for ALU/branch/trapped ops, 3 for stores, 4 or more for loads.
// Backpressure: ex_ready low while a dmem access is in flight or wb output is held by !wb_ready.
module mem_stage_hs
    import riscv_mem_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int DADDR_W       = 30,
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] branch_addr_from_execution,
    input  logic [XLEN-1:0] result_from_execution,
    input  logic [XLEN-1:0] rs2_data_from_execution,
    input  logic [2:0]      funct3_from_execution,
    input  logic [4:0]      rd_from_execution,
    input  logic            equal_from_execution,
    input  logic            lesser_from_execution,
    input  logic            greater_from_execution,
    input  logic            read_from_execution,
    input  logic            write_from_execution,
    input  logic            branch_from_execution,
    input  logic            u_branch_from_execution,
    input  logic            write_reg_from_execution,
    input  logic            select_from_execution,
    mem_stage_hs_if.master  dmem,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [XLEN-1:0] result_from_memory,
    output logic [4:0]      rd_from_memory,
    output logic            write_reg_from_memory,
    output logic            select_from_memory,
    output logic            misalign_from_memory,
    output logic            load_next_pc,
    output logic [XLEN-1:0] next_pc
);
    if (XLEN != 32) begin : g_xlen_check
        $error("mem_stage_hs supports XLEN=32 only");
    end

    typedef struct packed {
        logic               we;
        logic [DADDR_W-1:0] addr;
        logic [3:0]         be;
        logic [XLEN-1:0]    wdata;
        logic [1:0]         off;
        logic [2:0]         funct3;
        logic [XLEN-1:0]    result;
        logic [4:0]         rd;
        logic               write_reg;
        logic               select;
        logic               misalign;
    } req_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [4:0]      rd;
        logic            write_reg;
        logic            select;
        logic            misalign;
    } wb_t;

    mem_state_t      state_q, state_d;
    req_t            req_q, req_d;
    wb_t             wb_q, wb_d;
    logic            wb_valid_q, wb_valid_d;
    logic [XLEN-1:0] load_data_q, load_data_d;
    logic            load_next_pc_q, load_next_pc_d;
    logic [XLEN-1:0] next_pc_q, next_pc_d;

    logic            accept, is_mem, mis, trap, resolve;
    logic [1:0]      off;
    logic [3:0]      be_fmt;
    logic [XLEN-1:0] wdata_fmt, load_word;

    // Only lesser/equal are needed for the supported branch set
    logic unused_greater;
    assign unused_greater = greater_from_execution;

    assign ex_ready = (state_q == IDLE) && (!wb_valid_q || wb_ready);
    assign accept   = ex_valid && ex_ready;
    assign is_mem   = read_from_execution || write_from_execution;
    assign mis      = is_mem && misaligned(funct3_from_execution, result_from_execution[1:0]);
    assign trap     = MISALIGN_TRAP && mis;

    always_comb begin
        // Untrapped misaligned accesses are forced onto the natural boundary
        case (funct3_from_execution[1:0])
            2'b00:   off = result_from_execution[1:0];
            2'b01:   off = {result_from_execution[1], 1'b0};
            default: off = 2'b00;
        endcase
        case (funct3_from_execution)
            F3_SB: begin
                be_fmt    = 4'b0001 << off;
                wdata_fmt = {4{rs2_data_from_execution[7:0]}};
            end
            F3_SH: begin
                be_fmt    = 4'b0011 << off;
                wdata_fmt = {2{rs2_data_from_execution[15:0]}};
            end
            default: begin
                be_fmt    = 4'b1111;
                wdata_fmt = rs2_data_from_execution;
            end
        endcase
        case (funct3_from_execution)
            F3_BEQ:           resolve = equal_from_execution;
            F3_BNE:           resolve = !equal_from_execution;
            F3_BLT, F3_BLTU:  resolve = lesser_from_execution;
            F3_BGE, F3_BGEU:  resolve = !lesser_from_execution;
            default:          resolve = 1'b0;
        endcase
    end

    load_align_unit #(.XLEN(XLEN)) u_load_align (
        .rdata  (dmem.dmem_rdata),
        .off    (req_q.off),
        .funct3 (req_q.funct3),
        .result (load_word)
    );

    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        wb_d           = wb_q;
        wb_valid_d     = wb_valid_q && !wb_ready;
        load_data_d    = load_data_q;
        load_next_pc_d = 1'b0;
        next_pc_d      = next_pc_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    load_next_pc_d = (resolve && branch_from_execution) || u_branch_from_execution;
                    next_pc_d      = branch_addr_from_execution;
                    if (is_mem && !trap) begin
                        req_d = '{we:        write_from_execution,
                                  addr:      result_from_execution[DADDR_W+1:2],
                                  be:        be_fmt,
                                  wdata:     wdata_fmt,
                                  off:       off,
                                  funct3:    funct3_from_execution,
                                  result:    result_from_execution,
                                  rd:        rd_from_execution,
                                  write_reg: write_reg_from_execution,
                                  select:    select_from_execution,
                                  misalign:  mis};
                        state_d = REQ;
                    end else begin
                        wb_d = '{result:    result_from_execution,
                                 rd:        rd_from_execution,
                                 write_reg: write_reg_from_execution && !trap,
                                 select:    select_from_execution,
                                 misalign:  mis};
                        wb_valid_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (dmem.dmem_req_ready) state_d = req_q.we ? DONE : WAIT_RSP;
            end
            WAIT_RSP: begin
                if (dmem.dmem_rsp_valid) begin
                    load_data_d = load_word;
                    state_d     = DONE;
                end
            end
            DONE: begin
                wb_d = '{result:    req_q.select ? load_data_q : req_q.result,
                         rd:        req_q.rd,
                         write_reg: req_q.write_reg,
                         select:    req_q.select,
                         misalign:  req_q.misalign};
                wb_valid_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            req_q          <= '0;
            wb_q           <= '0;
            wb_valid_q     <= 1'b0;
            load_data_q    <= '0;
            load_next_pc_q <= 1'b0;
            next_pc_q      <= '0;
        end else begin
            state_q        <= state_d;
            req_q          <= req_d;
            wb_q           <= wb_d;
            wb_valid_q     <= wb_valid_d;
            load_data_q    <= load_data_d;
            load_next_pc_q <= load_next_pc_d;
            next_pc_q      <= next_pc_d;
        end
    end

    assign dmem.dmem_req_valid  = (state_q == REQ);
    assign dmem.dmem_we         = req_q.we;
    assign dmem.dmem_addr       = req_q.addr;
    assign dmem.dmem_be         = req_q.be;
    assign dmem.dmem_wdata      = req_q.wdata;
    assign wb_valid              = wb_valid_q;
    assign result_from_memory    = wb_q.result;
    assign rd_from_memory        = wb_q.rd;
    assign write_reg_from_memory = wb_q.write_reg;
    assign select_from_memory    = wb_q.select;
    assign misalign_from_memory  = wb_q.misalign;
    assign load_next_pc          = load_next_pc_q;
    assign next_pc               = next_pc_q;
endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs with a writeback scoreboard and a scripted data memory.
module tb_mem_stage_hs;
    import riscv_mem_pkg::*;

    localparam logic [7:0] C_RD = 8'h80, C_WR = 8'h40, C_BR = 8'h20, C_UBR = 8'h10;
    localparam logic [7:0] C_WREG = 8'h08, C_SEL = 8'h04, C_EQ = 8'h02, C_LT = 8'h01;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        ex_valid, ex_ready;
    logic [31:0] baddr_in, res_in, rs2_in;
    logic [2:0]  f3_in;
    logic [4:0]  rd_in;
    logic        eq_in, lt_in, gt_in, rd_en, wr_en, br_in, ubr_in, wreg_in, sel_in;
    logic        wb_valid, wb_ready;
    logic [31:0] res_mem, npc;
    logic [4:0]  rd_mem;
    logic        wreg_mem, sel_mem, mis_mem, lnpc;

    mem_stage_hs_if dmem();

    mem_stage_hs dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .branch_addr_from_execution(baddr_in), .result_from_execution(res_in),
        .rs2_data_from_execution(rs2_in), .funct3_from_execution(f3_in),
        .rd_from_execution(rd_in), .equal_from_execution(eq_in),
        .lesser_from_execution(lt_in), .greater_from_execution(gt_in),
        .read_from_execution(rd_en), .write_from_execution(wr_en),
        .branch_from_execution(br_in), .u_branch_from_execution(ubr_in),
        .write_reg_from_execution(wreg_in), .select_from_execution(sel_in),
        .dmem(dmem.master), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .result_from_memory(res_mem), .rd_from_memory(rd_mem),
        .write_reg_from_memory(wreg_mem), .select_from_memory(sel_mem),
        .misalign_from_memory(mis_mem), .load_next_pc(lnpc), .next_pc(npc)
    );

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        wr;
        logic        sel;
        logic        mis;
    } wb_exp_t;

    wb_exp_t sb[$];
    wb_exp_t mon_got, mon_exp;
    int checks = 0;
    int failures = 0;

    function automatic wb_exp_t mk(input logic [31:0] r, input logic [4:0] d,
                                   input logic w, input logic s, input logic m);
        return {r, d, w, s, m};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_valid = 1'b0; baddr_in = '0; res_in = '0; rs2_in = '0; f3_in = '0; rd_in = '0;
        {rd_en, wr_en, br_in, ubr_in, wreg_in, sel_in, eq_in, lt_in} = 8'h00;
        gt_in = 1'b0;
    endtask

    // Present one instruction, wait for acceptance, and return one cycle after the accept edge
    task automatic send(input logic [31:0] res, input logic [31:0] rs2v, input logic [31:0] ba,
                        input logic [2:0] f3, input logic [4:0] rdv, input logic [7:0] ctl,
                        input bit push, input wb_exp_t exp);
        int n;
        res_in = res; rs2_in = rs2v; baddr_in = ba; f3_in = f3; rd_in = rdv;
        {rd_en, wr_en, br_in, ubr_in, wreg_in, sel_in, eq_in, lt_in} = ctl;
        gt_in = !eq_in && !lt_in;
        ex_valid = 1'b1;
        #1;
        n = 0;
        while (!ex_ready && n < 20) begin
            tick();
            n++;
        end
        check("accept_ex_ready", 32'(ex_ready), 32'd1);
        if (push) sb.push_back(exp);
        tick();
        clear_ex();
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] raw,
                           input logic [4:0] rdv, input logic [31:0] exp_res);
        send(addr, 32'h0, 32'h0, f3, rdv, C_RD | C_WREG | C_SEL, 1'b1, mk(exp_res, rdv, 1'b1, 1'b1, 1'b0));
        check("ld_req_valid", 32'(dmem.dmem_req_valid), 32'd1);
        check("ld_we", 32'(dmem.dmem_we), 32'd0);
        check("ld_addr", 32'(dmem.dmem_addr), addr >> 2);
        dmem.dmem_req_ready = 1'b1;
        tick();
        dmem.dmem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("ld_wait_ex_ready", 32'(ex_ready), 32'd0);
            check("ld_wait_wb_valid", 32'(wb_valid), 32'd0);
            tick();
        end
        dmem.dmem_rdata = raw;
        dmem.dmem_rsp_valid = 1'b1;
        tick();
        dmem.dmem_rsp_valid = 1'b0;
        dmem.dmem_rdata = 32'hDEAD_BEEF;
        check("ld_done_wb_valid", 32'(wb_valid), 32'd0);
        tick();
        check("ld_wb_valid", 32'(wb_valid), 32'd1);
        check("ld_result", res_mem, exp_res);
    endtask

    // Scoreboard: every writeback handshake must match the oldest pending expectation
    always @(negedge clk) begin
        if (wb_valid && wb_ready) begin
            mon_got = {res_mem, rd_mem, wreg_mem, sel_mem, mis_mem};
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL wb_unexpected observed=0x%010h expected=none", mon_got);
            end
            if (sb.size() != 0) begin
                mon_exp = sb.pop_front();
                checks++;
                assert (mon_got === mon_exp) else begin
                    failures++;
                    $error("FAIL wb_scoreboard observed=0x%010h expected=0x%010h", mon_got, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        clear_ex();
        wb_ready = 1'b1;
        dmem.dmem_req_ready = 1'b0;
        dmem.dmem_rsp_valid = 1'b0;
        dmem.dmem_rdata = 32'hDEAD_BEEF;
        repeat (3) tick();
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_req_valid", 32'(dmem.dmem_req_valid), 32'd0);
        check("rst_lnpc", 32'(lnpc), 32'd0);
        check("rst_ex_ready", 32'(ex_ready), 32'd1);
        rst = 1'b1;
        tick();

        // ALU op, latency 1, no memory request
        send(32'h1234, 32'h0, 32'h0, 3'b000, 5'd5, C_WREG, 1'b1, mk(32'h1234, 5'd5, 1'b1, 1'b0, 1'b0));
        check("alu_wb_valid", 32'(wb_valid), 32'd1);
        check("alu_result", res_mem, 32'h1234);
        check("alu_no_req", 32'(dmem.dmem_req_valid), 32'd0);

        // SB at byte 3 with a memory that stalls ready for 3 cycles
        send(32'h103, 32'hAB, 32'h0, F3_SB, 5'd0, C_WR, 1'b1, mk(32'h103, 5'd0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            check("sb_req_valid", 32'(dmem.dmem_req_valid), 32'd1);
            check("sb_addr", 32'(dmem.dmem_addr), 32'h40);
            check("sb_be", 32'(dmem.dmem_be), 32'h8);
            check("sb_wdata", dmem.dmem_wdata, 32'hABAB_ABAB);
            check("sb_we", 32'(dmem.dmem_we), 32'd1);
            check("sb_ex_ready", 32'(ex_ready), 32'd0);
            tick();
        end
        dmem.dmem_req_ready = 1'b1;
        tick();
        dmem.dmem_req_ready = 1'b0;
        check("sb_done_req_valid", 32'(dmem.dmem_req_valid), 32'd0);
        check("sb_done_wb_valid", 32'(wb_valid), 32'd0);
        tick();
        check("sb_wb_valid", 32'(wb_valid), 32'd1);

        // SH at offset 2: half lanes
        send(32'h206, 32'h0000_BEEF, 32'h0, F3_SH, 5'd0, C_WR, 1'b1, mk(32'h206, 5'd0, 1'b0, 1'b0, 1'b0));
        check("sh_be", 32'(dmem.dmem_be), 32'hC);
        check("sh_wdata", dmem.dmem_wdata, 32'hBEEF_BEEF);
        dmem.dmem_req_ready = 1'b1;
        tick();
        dmem.dmem_req_ready = 1'b0;
        tick();

        // Loads: sign/zero extension across lanes
        do_load(F3_LB,  32'h102, 32'h0080_0000, 5'd7, 32'hFFFF_FF80);
        do_load(F3_LBU, 32'h102, 32'h0080_0000, 5'd7, 32'h0000_0080);
        do_load(F3_LB,  32'h103, 32'h7F00_0000, 5'd8, 32'h0000_007F);
        do_load(F3_LH,  32'h102, 32'h8001_0000, 5'd6, 32'hFFFF_8001);
        do_load(F3_LHU, 32'h102, 32'h8001_0000, 5'd6, 32'h0000_8001);
        do_load(F3_LW,  32'h104, 32'h1234_5678, 5'd4, 32'h1234_5678);

        // Branches: single-cycle redirect pulse only when taken
        send(32'h0, 32'h0, 32'h8000_0100, F3_BNE, 5'd0, C_BR, 1'b1, mk(32'h0, 5'd0, 1'b0, 1'b0, 1'b0));
        check("bne_lnpc", 32'(lnpc), 32'd1);
        check("bne_npc", npc, 32'h8000_0100);
        tick();
        check("bne_pulse_end", 32'(lnpc), 32'd0);
        send(32'h0, 32'h0, 32'h8000_0200, F3_BEQ, 5'd0, C_BR, 1'b1, mk(32'h0, 5'd0, 1'b0, 1'b0, 1'b0));
        check("beq_not_taken", 32'(lnpc), 32'd0);
        send(32'h0, 32'h0, 32'h8000_0300, F3_BLT, 5'd0, C_BR | C_LT, 1'b1, mk(32'h0, 5'd0, 1'b0, 1'b0, 1'b0));
        check("blt_taken", 32'(lnpc), 32'd1);
        send(32'h0, 32'h0, 32'h8000_0400, F3_BGE, 5'd0, C_BR | C_LT, 1'b1, mk(32'h0, 5'd0, 1'b0, 1'b0, 1'b0));
        check("bge_not_taken", 32'(lnpc), 32'd0);
        send(32'h44, 32'h0, 32'h8000_0500, 3'b000, 5'd1, C_UBR | C_WREG, 1'b1, mk(32'h44, 5'd1, 1'b1, 1'b0, 1'b0));
        check("jal_lnpc", 32'(lnpc), 32'd1);
        check("jal_npc", npc, 32'h8000_0500);
        tick();

        // Misaligned accesses trap: no request, latency 1
        send(32'h102, 32'h0, 32'h0, F3_LW, 5'd9, C_RD | C_WREG | C_SEL, 1'b1, mk(32'h102, 5'd9, 1'b0, 1'b1, 1'b1));
        check("mis_lw_wb_valid", 32'(wb_valid), 32'd1);
        check("mis_lw_no_req", 32'(dmem.dmem_req_valid), 32'd0);
        check("mis_lw_flag", 32'(mis_mem), 32'd1);
        check("mis_lw_wreg", 32'(wreg_mem), 32'd0);
        send(32'h101, 32'h55, 32'h0, F3_SH, 5'd0, C_WR, 1'b1, mk(32'h101, 5'd0, 1'b0, 1'b0, 1'b1));
        check("mis_sh_no_req", 32'(dmem.dmem_req_valid), 32'd0);
        tick();

        // Output hold under writeback backpressure
        wb_ready = 1'b0;
        send(32'h55AA, 32'h0, 32'h0, 3'b000, 5'd3, C_WREG, 1'b1, mk(32'h55AA, 5'd3, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            check("hold_wb_valid", 32'(wb_valid), 32'd1);
            check("hold_result", res_mem, 32'h55AA);
            check("hold_ex_ready", 32'(ex_ready), 32'd0);
            tick();
        end
        wb_ready = 1'b1;
        repeat (2) tick();

        // Reset while waiting for a load response; the late response must be ignored
        send(32'h200, 32'h0, 32'h0, F3_LW, 5'd2, C_RD | C_WREG | C_SEL, 1'b0, mk(32'h0, 5'd0, 1'b0, 1'b0, 1'b0));
        dmem.dmem_req_ready = 1'b1;
        tick();
        dmem.dmem_req_ready = 1'b0;
        check("rstw_state_wait", 32'(dut.state_q), 32'(WAIT_RSP));
        rst = 1'b0;
        tick();
        check("rstw_state_idle", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b1;
        dmem.dmem_rdata = 32'h1111_1111;
        dmem.dmem_rsp_valid = 1'b1;
        tick();
        dmem.dmem_rsp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rstw_wb_valid", 32'(wb_valid), 32'd0);
            check("rstw_req_valid", 32'(dmem.dmem_req_valid), 32'd0);
            check("rstw_result", res_mem, 32'h0);
            check("rstw_npc", npc, 32'h0);
            check("rstw_state", 32'(dut.state_q), 32'(IDLE));
            tick();
        end

        n = 0;
        while (sb.size() != 0 && n < 10) begin
            tick();
            n++;
        end
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
